// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access definitions: funct3 size/sign codes, LSU state
// encoding and the legality/alignment helpers used by the load/store unit.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Unsigned sizes only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return !lo[0];
            default: return lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: replicates store data across lanes with its byte enables,
// and extracts/extends the addressed lane of a loaded word.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [15:0] lane;

    assign lane = 16'(rdata >> {addr_lo, 3'b000});

    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = rdata;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data = {24'b0, lane[7:0]};
            F3_HU:   load_data = {16'b0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one registered data-memory access per
// accepted instruction, stalls the pipeline until it completes, aligns loads.
module mem_stage_lsu
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        fault_out,
    output logic        stall_out,
    output lsu_state_e  state_dbg
);

    // Handshake: dmem_req is the valid; once raised, dmem_we/addr/wdata/be stay
    // frozen until the cycle in which dmem_ready is high, which completes the
    // access on that rising edge. dmem_ready is ignored while dmem_req is low.

    lsu_state_e  state;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;
    logic        lat_load;

    logic        one_op;
    logic        any_op;
    logic        accept;
    logic        fault_cond;
    logic [2:0]  align_f3;
    logic [1:0]  align_lo;
    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic [31:0] align_load;

    assign one_op     = start && (mem_read_in ^ mem_write_in);
    assign any_op     = start && (mem_read_in | mem_write_in);
    assign accept     = (state == LSU_IDLE) && one_op
                        && f3_legal(funct3_in, mem_write_in)
                        && addr_aligned(funct3_in, addr_in[1:0]);
    assign fault_cond = (state == LSU_IDLE) && any_op && !accept;

    // Stores are steered from the live inputs; loads from the latched access.
    assign align_f3 = (state == LSU_IDLE) ? funct3_in     : lat_f3;
    assign align_lo = (state == LSU_IDLE) ? addr_in[1:0]  : lat_lo;

    lsu_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_lo),
        .store_data (store_data_in),
        .rdata      (dmem_rdata),
        .wdata      (align_wdata),
        .be         (align_be),
        .load_data  (align_load)
    );

    assign stall_out = !reset && (accept || (state == LSU_REQ));
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LSU_IDLE;
            lat_f3         <= 3'b000;
            lat_lo         <= 2'b00;
            lat_load       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0;
            dmem_wdata     <= 32'h0;
            dmem_be        <= 4'b0000;
            load_data_out  <= 32'h0;
            load_valid_out <= 1'b0;
            fault_out      <= 1'b0;
        end else begin
            fault_out      <= 1'b0;
            load_valid_out <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        state      <= LSU_REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in;
                        dmem_addr  <= {addr_in[31:2], 2'b00};
                        dmem_wdata <= mem_write_in ? align_wdata : 32'h0;
                        dmem_be    <= align_be;
                        lat_f3     <= funct3_in;
                        lat_lo     <= addr_in[1:0];
                        lat_load   <= mem_read_in;
                    end else begin
                        fault_out  <= fault_cond;
                    end
                end
                LSU_REQ: begin
                    if (dmem_ready) begin
                        state    <= LSU_DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= 4'b0000;
                        if (lat_load) begin
                            load_data_out  <= align_load;
                            load_valid_out <= 1'b1;
                        end
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-003 start  input  1  pipeline enable; a new access is accepted only while high.
REQ-004 mem_read_in  input  1  current instruction is a load.
REQ-005 mem_write_in  input  1  current instruction is a store.
REQ-006 funct3_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr_in  input  32  byte address from ALU.
REQ-008 store_data_in  input  32  rs2 value for stores.
REQ-009 dmem_req  output  1  registered request to data memory.
REQ-010 dmem_we  output  1  registered write enable, valid while dmem_req.
REQ-011 dmem_addr  output  32  registered word address, {addr_in[31:2],2'b00}.
REQ-012 dmem_wdata  output  32  registered lane-replicated store data.
REQ-013 dmem_be  output  4  registered byte enables.
REQ-014 dmem_ready  input  1  memory completes the access this cycle; sampled only while dmem_req is high.
REQ-015 dmem_rdata  input  32  read word, valid with dmem_ready on loads.
REQ-016 load_data_out  output  32  aligned, extended load result to the MEM/WB register.
REQ-017 load_valid_out  output  1  one-cycle pulse when load_data_out updates.
REQ-018 fault_out  output  1  one-cycle pulse on misaligned or illegal access.
REQ-019 stall_out  output  1  freezes upstream stages while an access is outstanding.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE; reset state IDLE.
REQ-021 IDLE: start=1 and exactly one of mem_read_in/mem_write_in, legal funct3, aligned address -> latch size, sign, addr[1:0]; drive dmem_* registered; next REQ.
REQ-022 Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=00; B/BU always aligned.
REQ-023 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; others illegal.
REQ-024 Misaligned, illegal, or both read and write high while start=1 in IDLE -> no request, fault_out=1 next cycle, stay IDLE, stall_out=0.
REQ-025 start=0 in IDLE -> no request, no fault, all pulses low.
REQ-026 stall_out SHALL be combinationally high in IDLE on an accepted access and throughout REQ; low in DONE and otherwise.
REQ-027 REQ: dmem_req and all dmem_* outputs held stable until dmem_ready=1; start is ignored (no abort).
REQ-028 REQ with dmem_ready=1: dmem_req low next cycle; next DONE; for loads load_data_out and load_valid_out=1 updated on that same edge.
REQ-029 DONE lasts exactly one cycle, then IDLE; no new access accepted in DONE.
REQ-030 Minimum latency: accept at edge N, dmem_req high N..N+1, ready in cycle N+1 -> load_data_out valid after edge N+2.
REQ-031 SB: wdata = byte replicated x4, be = 1<<addr[1:0]; SH: halfword replicated x2, be = 0011 (addr[1]=0) or 1100; SW: be=1111.
REQ-032 Loads: select lane by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-033 load_data_out holds its value between loads; stores never change it.
REQ-034 dmem_we=1 only for stores; dmem_be=0000 whenever dmem_req=0.

Reset
REQ-035 Reset SHALL force IDLE immediately and clear every output to 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_data_out, load_valid_out, fault_out, stall_out).
REQ-036 Reset during REQ SHALL drop dmem_req asynchronously; the pending access is discarded, no load_valid_out after release.

Structure
REQ-037 Shared package rv32i_pkg SHALL hold funct3 size/sign constants and the LSU state encoding.
REQ-038 Byte-lane store replication and load extraction/extension SHALL live in one combinational sub-module lsu_align.

Verification
REQ-039 LW addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF -> stall 4 cycles, load_data_out=0xDEADBEEF, one load_valid pulse.
REQ-040 LB addr 0x103, rdata 0x80112233 -> load_data_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SH addr 0x202, data 0x0000ABCD -> dmem_addr 0x200, wdata 0xABCDABCD, be 1100, we=1, no load_valid.
REQ-042 LW addr 0x101 -> no dmem_req, fault_out one-cycle pulse, stall_out 0; funct3 011 load -> same.
REQ-043 Reset asserted mid-REQ -> dmem_req low same cycle, all outputs 0, IDLE, no load_valid after release.
REQ-044 start deasserted during REQ -> access completes normally; start=0 in IDLE with mem_read_in=1 -> no request.
